bconv_kxk_stream: RTL and testbench



---
 rtl/bconv_kxk_stream.sv | 190 +++++++++++++++++++
 tb/tb_bconv_kxk_stream.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bconv_kxk_stream.sv
// Streaming KxK binary convolution with XNOR-popcount thresholding; one packed output row per handshake.
// Define BCONV_PAD_EN for "same" zero padding (K/2 zero columns before and after each row).
module bconv_kxk_stream #(
    parameter int K = 3,
    parameter int W = 16,
    localparam int CNT_W = $clog2(K*K+1),
    localparam int NC_W  = $clog2(W+1)
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               cfg_load,
    input  logic [K*K-1:0]     cfg_weights,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic               col_valid,
    output logic               col_ready,
    input  logic [K-1:0]       col_data,
    input  logic               col_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic [NC_W-1:0]    out_ncols,
    output logic               busy,
    output logic               ovf
);

    localparam int CW = $clog2(K+1);
    localparam logic [CNT_W-1:0] THR_RST = CNT_W'((K*K+1)/2);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] FILL = 3'd1;
    localparam logic [2:0] RUN  = 3'd2;
    localparam logic [2:0] EMIT = 3'd3;
`ifdef BCONV_PAD_EN
    localparam logic [2:0] PAD  = 3'd4;
    localparam int P = K/2;
`else
    localparam int P = 0;
`endif

    logic [2:0]       state_q, state_d;
    logic [K*K-1:0]   weights_q, weights_d;
    logic [CNT_W-1:0] thresh_q, thresh_d;
    logic [K*K-1:0]   window_q, window_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NC_W-1:0]  idx_q, idx_d;
    logic [W-1:0]     data_q, data_d;
    logic             ovf_q, ovf_d;
`ifdef BCONV_PAD_EN
    logic [CW-1:0]    padcnt_q, padcnt_d;
`endif

    logic             accept;
    logic             shift;
    logic             produce;
    logic             outBit;
    logic [CNT_W-1:0] mism;
    logic [K*K-1:0]   winBase;
    logic [K*K-1:0]   winShift;
    logic [CW-1:0]    cntBase;

    assign col_ready = !reset_b && (state_q == IDLE || state_q == FILL || state_q == RUN);
    assign accept    = col_valid && col_ready;
    assign out_valid = (state_q == EMIT);
    assign out_data  = data_q;
    assign out_ncols = idx_q;
    assign busy      = (state_q != IDLE);
    assign ovf       = ovf_q;

`ifdef BCONV_PAD_EN
    assign shift = accept || (state_q == PAD);
`else
    assign shift = accept;
`endif

    // A new row always starts from an all-zero window; padding relies on this for its leading columns.
    always_comb begin
        winBase  = (state_q == IDLE) ? '0 : window_q;
        winShift = '0;
        for (int r = 0; r < K; r++) begin
            winShift[r*K] = accept ? col_data[r] : 1'b0;
            for (int c = 1; c < K; c++) begin
                winShift[r*K+c] = winBase[r*K+c-1];
            end
        end
        mism = '0;
        for (int i = 0; i < K*K; i++) begin
            mism = mism + CNT_W'(winShift[i] ^ weights_q[i]);
        end
    end

    assign cntBase = (state_q == IDLE) ? CW'(P) : cnt_q;
    assign produce = shift && (cntBase >= CW'(K-1));
    assign outBit  = (mism >= thresh_q);

    always_comb begin
        state_d   = state_q;
        weights_d = weights_q;
        thresh_d  = thresh_q;
        window_d  = shift ? winShift : window_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        ovf_d     = ovf_q;
`ifdef BCONV_PAD_EN
        padcnt_d  = padcnt_q;
`endif

        if (shift) begin
            cnt_d = (cntBase >= CW'(K)) ? CW'(K) : cntBase + CW'(1);
        end

        // Bits beyond the word are dropped; the count saturates at W and ovf records the loss.
        if (produce) begin
            if (idx_q < NC_W'(W)) begin
                data_d = data_q | ({{(W-1){1'b0}}, outBit} << idx_q);
                idx_d  = idx_q + NC_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (state_q == IDLE && cfg_load && !accept) begin
            weights_d = cfg_weights;
            thresh_d  = cfg_thresh;
        end

        case (state_q)
            IDLE, FILL, RUN: begin
                if (accept) begin
                    if (col_last) begin
`ifdef BCONV_PAD_EN
                        state_d  = PAD;
                        padcnt_d = '0;
`else
                        state_d  = EMIT;
`endif
                    end else begin
                        state_d = produce ? RUN : FILL;
                    end
                end
            end
`ifdef BCONV_PAD_EN
            PAD: begin
                if (padcnt_q == CW'(P-1)) begin
                    state_d = EMIT;
                end else begin
                    padcnt_d = padcnt_q + CW'(1);
                end
            end
`endif
            EMIT: begin
                if (out_ready) begin
                    state_d = IDLE;
                    data_d  = '0;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            state_q   <= IDLE;
            weights_q <= '0;
            thresh_q  <= THR_RST;
            window_q  <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
`ifdef BCONV_PAD_EN
            padcnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            weights_q <= weights_d;
            thresh_q  <= thresh_d;
            window_q  <= window_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
`ifdef BCONV_PAD_EN
            padcnt_q  <= padcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_bconv_kxk_stream.sv
// Scoreboard bench for bconv_kxk_stream: a reference convolution model predicts each row word.
// Honours BCONV_PAD_EN so the same bench covers both builds.
module tb_bconv_kxk_stream;

    localparam int K = 3;
    localparam int W = 16;
    localparam int CNT_W = $clog2(K*K+1);
    localparam int NC_W  = $clog2(W+1);
`ifdef BCONV_PAD_EN
    localparam int P = K/2;
`else
    localparam int P = 0;
`endif

    logic             clk = 1'b0;
    logic             reset_b = 1'b1;
    logic             cfg_load = 1'b0;
    logic [K*K-1:0]   cfg_weights = '0;
    logic [CNT_W-1:0] cfg_thresh = '0;
    logic             col_valid = 1'b0;
    logic             col_ready;
    logic [K-1:0]     col_data = '0;
    logic             col_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic [NC_W-1:0]  out_ncols;
    logic             busy;
    logic             ovf;

    bconv_kxk_stream #(.K(K), .W(W)) dut (
        .clk(clk), .reset_b(reset_b), .cfg_load(cfg_load), .cfg_weights(cfg_weights),
        .cfg_thresh(cfg_thresh), .col_valid(col_valid), .col_ready(col_ready),
        .col_data(col_data), .col_last(col_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ncols(out_ncols),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           ncols;
    } exp_t;

    exp_t           sbQ[$];
    logic [K-1:0]   colBuf[64];
    logic [K*K-1:0] modW = '0;
    int             modT = (K*K+1)/2;
    logic           expOvf = 1'b0;
    int             checksTotal = 0;
    int             checksPassed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        if (observed === expected) checksPassed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    endtask

    // Reference: zero-extend the row by P columns each side, slide a KxK window, threshold the mismatch count.
    function automatic void modelRow(input int n, output logic [W-1:0] d, output int nc, output logic ov);
        logic [K-1:0]   ext[80];
        logic [K*K-1:0] win;
        int total, outs, mm;
        total = n + 2*P;
        for (int i = 0; i < total; i++) ext[i] = (i < P || i >= P+n) ? '0 : colBuf[i-P];
        outs = total - K + 1;
        d = '0;
        for (int j = 0; j < outs; j++) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    win[r*K+c] = ext[j+K-1-c][r];
            mm = $countones(win ^ modW);
            if (j < W) d[j] = (mm >= modT);
        end
        nc = (outs < 0) ? 0 : ((outs > W) ? W : outs);
        ov = (outs > W);
    endfunction

    task automatic loadCfg(input logic [K*K-1:0] w, input int t);
        checkOutput("cfgIdle", busy, 0);
        cfg_load = 1'b1; cfg_weights = w; cfg_thresh = CNT_W'(t);
        @(negedge clk);
        cfg_load = 1'b0;
        modW = w; modT = t;
    endtask

    // mode 0: all ones, 1: all zeros, 2: random with gaps. cfgPoke tries loads the DUT must ignore.
    task automatic applyStimulus(input int n, input int mode, input int stall, input bit cfgPoke);
        exp_t e;
        logic ov;
        int wt, lat;
        for (int i = 0; i < n; i++)
            colBuf[i] = (mode == 0) ? '1 : (mode == 1) ? '0 : K'($urandom);
        modelRow(n, e.data, e.ncols, ov);
        if (ov) expOvf = 1'b1;
        sbQ.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (mode == 2 && $urandom_range(3) == 0) begin
                col_valid = 1'b0;
                @(negedge clk);
            end
            col_valid = 1'b1; col_data = colBuf[i]; col_last = (i == n-1);
            if (cfgPoke && (i == 0 || i == 2)) begin
                cfg_load = 1'b1; cfg_weights = ~modW; cfg_thresh = CNT_W'(1);
            end
            wt = 0;
            while (!col_ready && wt < 20) begin @(negedge clk); wt++; end
            if (wt == 20) checkOutput("colReadyTimeout", 0, 1);
            @(negedge clk);
            cfg_load = 1'b0;
        end
        col_valid = 1'b0; col_last = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
        checkOutput("latency", lat, 1+P);
        for (int s = 0; s < stall; s++) begin
            checkOutput("stallColReady", col_ready, 0);
            checkOutput("stallData", out_data, sbQ[0].data);
            @(negedge clk);
        end
        checkOutput("outValid", out_valid, 1);
        e = sbQ.pop_front();
        checkOutput("outData", out_data, e.data);
        checkOutput("outNcols", out_ncols, e.ncols);
        checkOutput("ovf", ovf, expOvf);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("busyAfter", busy, 0);
        checkOutput("validAfter", out_valid, 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Valid"}, out_valid, 0);
        checkOutput({tag, "Data"}, out_data, 0);
        checkOutput({tag, "Ncols"}, out_ncols, 0);
        checkOutput({tag, "Busy"}, busy, 0);
        checkOutput({tag, "Ovf"}, ovf, 0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstColReady", col_ready, 0);
        checkResetState("rst");
        reset_b = 1'b0;
        @(negedge clk);
        checkResetState("idle");
        checkOutput("idleColReady", col_ready, 1);

        applyStimulus(16, 0, 0, 0);
        loadCfg(9'h1FF, 5);
        applyStimulus(16, 0, 0, 0);
        applyStimulus(16, 1, 0, 0);

        loadCfg(K*K'($urandom), 4);
        applyStimulus(12, 2, 10, 1);
        loadCfg(K*K'($urandom), 3);
        applyStimulus(16, 2, 0, 0);

        applyStimulus(2, 0, 0, 0);
        applyStimulus(20, 2, 0, 0);
        applyStimulus(9, 2, 0, 0);

        for (int i = 0; i < 7; i++) begin
            col_valid = 1'b1; col_data = '1; col_last = 1'b0;
            @(negedge clk);
        end
        col_valid = 1'b0;
        reset_b = 1'b1;
        @(negedge clk);
        checkOutput("midRstColReady", col_ready, 0);
        @(negedge clk);
        reset_b = 1'b0;
        modW = '0; modT = (K*K+1)/2; expOvf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkResetState("postRst");
            @(negedge clk);
        end
        applyStimulus(5, 0, 0, 0);

        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
